// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (16x baud), LSB-first framing.
//
// The serial line is brought through a 2-flop synchronizer, then sampled by an
// FSM stepped by a free-running oversample tick. The start bit is confirmed at
// its midpoint, each data bit is sampled 16 ticks later (bit centre), and the
// stop bit SB_TICK ticks after the last data bit.
//
// Parameters:
//   DBIT     - data bits per frame
//   SB_TICK  - oversample ticks in the stop bit (at most 16)
//   BAUD_DIV - clk cycles per oversample tick
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   rx         - serial input, asynchronous, idles high
//   d_out      - last received data word, held until the next frame completes
//   rx_done    - one-cycle pulse when a frame completes
//   frame_err  - 1 when the last frame had a low stop bit
//   parity_err - (UART_RX_PARITY_EN only) 1 when the last frame failed even parity
//
// Build option:
//   UART_RX_PARITY_EN - adds an even-parity bit between the data and stop bits
//                       plus the parity_err output. Undefined gives 8N1 framing.

module uart_rx #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned BAUD_DIV = 163
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);
    localparam logic [NW-1:0]   NLast  = NW'(DBIT - 1);
    localparam logic [3:0]      SLast  = 4'(SB_TICK - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // ------------------------------------------------------------------
    // Input synchronizer; resets to the idle (high) line level
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Free-running oversample tick generator
    // ------------------------------------------------------------------
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            tick;

    assign tick  = (cnt_q == CntMax);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] d_out_q, d_out_d;
    logic            ferr_q, ferr_d;
    logic            done_q, done_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        d_out_d = d_out_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif

        unique case (state_q)
            // No tick qualification here: a start edge seen on the very cycle
            // IDLE is re-entered is taken, so back-to-back frames are not lost.
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end

            // Confirm the start bit at its midpoint; a high line there is a glitch.
            StStart: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end

            // Sample each data bit at its centre, LSB first into the MSB end.
            StData: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = DBIT'({rx_s, b_q} >> 1);
                        if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = '0;
                        par_d   = rx_s;
                        state_d = StStop;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif

            // Deliver the word even on a bad stop bit; frame_err flags it.
            StStop: begin
                if (tick) begin
                    if (s_q == SLast) begin
                        d_out_d = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{b_q, par_q};
`endif
                        state_d = StIdle;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            d_out_q <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            d_out_q <= d_out_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign d_out     = d_out_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx with BAUD_DIV=4
// (one bit time = 64 clk cycles).

module tb_uart_rx;

    localparam int unsigned BaudDiv = 4;
    localparam int unsigned BitCyc  = 16 * BaudDiv;
    // Non-idle stop level is held this long, then the line returns high.
    localparam int unsigned StopLow = 40;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16),
        .BAUD_DIV(BaudDiv)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .d_out    (d_out),
        .rx_done  (rx_done),
        .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // rx_done monitor: records every high cycle with the outputs seen then.
    int unsigned done_cnt = 0;
    logic [7:0]  cap_data[$];
    logic        cap_ferr[$];
`ifdef UART_RX_PARITY_EN
    logic        cap_perr[$];
`endif

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cnt++;
            cap_data.push_back(d_out);
            cap_ferr.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
            cap_perr.push_back(parity_err);
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] cap_data_at(input int back);
        if (cap_data.size() >= back) return cap_data[cap_data.size() - back];
        return 8'hxx;
    endfunction

    function automatic logic cap_ferr_last();
        if (cap_ferr.size() > 0) return cap_ferr[cap_ferr.size() - 1];
        return 1'bx;
    endfunction

    task automatic idle(input int unsigned cyc);
        rx = 1'b1;
        repeat (cyc) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, [even parity], stop.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        rx = 1'b0;
        repeat (BitCyc) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = data[k];
            repeat (BitCyc) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^data;
        repeat (BitCyc) @(negedge clk);
`endif
        rx = stop;
        repeat (StopLow) @(negedge clk);
        rx = 1'b1;
        repeat (BitCyc - StopLow) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] data, input logic par);
        rx = 1'b0;
        repeat (BitCyc) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = data[k];
            repeat (BitCyc) @(negedge clk);
        end
        rx = par;
        repeat (BitCyc) @(negedge clk);
        rx = 1'b1;
        repeat (BitCyc) @(negedge clk);
    endtask
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int unsigned base;

        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_ferr: 1'b1};
        vecs[2] = '{data: 8'h3C, stop: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'hC6, stop: 1'b1, exp_ferr: 1'b0};

        // Reset state
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("reset d_out", 32'(d_out), 32'h00);
        check("reset rx_done", 32'(rx_done), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
`ifdef UART_RX_PARITY_EN
        check("reset parity_err", 32'(parity_err), 32'h0);
`endif
        reset = 1'b1;
        idle(20);

        // Single frames, including a bad stop bit followed by a good one
        for (int i = 0; i < 5; i++) begin
            base = done_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(32);
            check($sformatf("vec%0d rx_done cycles", i), done_cnt - base, 32'd1);
            check($sformatf("vec%0d data at done", i), 32'(cap_data_at(1)),
                  32'(vecs[i].data));
            check($sformatf("vec%0d frame_err at done", i), 32'(cap_ferr_last()),
                  32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d d_out held", i), 32'(d_out), 32'(vecs[i].data));
            check($sformatf("vec%0d frame_err held", i), 32'(frame_err),
                  32'(vecs[i].exp_ferr));
        end

        // Start glitch: 4 ticks low, then high
        base = done_cnt;
        rx = 1'b0;
        repeat (4 * BaudDiv) @(negedge clk);
        idle(100);
        check("glitch no rx_done", done_cnt - base, 32'd0);
        check("glitch d_out unchanged", 32'(d_out), 32'hC6);
        base = done_cnt;
        send_frame(8'h96, 1'b1);
        idle(32);
        check("post-glitch rx_done", done_cnt - base, 32'd1);
        check("post-glitch d_out", 32'(d_out), 32'h96);

        // Reset in the middle of data bit 3 of 0xFF
        base = done_cnt;
        rx = 1'b0;
        repeat (BitCyc) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BitCyc + BitCyc / 2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset d_out", 32'(d_out), 32'h00);
        check("midreset frame_err", 32'(frame_err), 32'h0);
        check("midreset rx_done", 32'(rx_done), 32'h0);
        reset = 1'b1;
        idle(7 * BitCyc);
        check("midreset no rx_done", done_cnt - base, 32'd0);
        check("midreset d_out after", 32'(d_out), 32'h00);
        base = done_cnt;
        send_frame(8'h0F, 1'b1);
        idle(32);
        check("after-reset rx_done", done_cnt - base, 32'd1);
        check("after-reset d_out", 32'(d_out), 32'h0F);

        // Back-to-back frames
        base = done_cnt;
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'hFE, 1'b1);
        idle(32);
        check("b2b rx_done cycles", done_cnt - base, 32'd3);
        check("b2b first", 32'(cap_data_at(3)), 32'h01);
        check("b2b second", 32'(cap_data_at(2)), 32'h80);
        check("b2b third", 32'(cap_data_at(1)), 32'hFE);

`ifdef UART_RX_PARITY_EN
        // Even parity: ^0x07 = 1, so a parity bit of 1 is correct
        base = done_cnt;
        send_frame_par(8'h07, 1'b0);
        idle(32);
        check("par0 rx_done", done_cnt - base, 32'd1);
        check("par0 d_out", 32'(d_out), 32'h07);
        check("par0 parity_err", 32'(parity_err), 32'h1);
        base = done_cnt;
        send_frame_par(8'h07, 1'b1);
        idle(32);
        check("par1 rx_done", done_cnt - base, 32'd1);
        check("par1 parity_err", 32'(parity_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
